// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: frames a parallel byte as start, LSB-first data,
// optional parity and stop bit, shifting one bit per clock onto TX_OUT.
// TX_OUT and Busy are registered and always describe the state being entered.
//
// Handshake: DATA_VALID is a single-cycle request that is accepted only on a
// clock edge where the serializer is in IDLE. Requests arriving while Busy is
// high, including the STOP cycle, are dropped rather than queued. Busy is the
// de-facto "not ready" indication seen by the upstream stage.
module uart_tx_serializer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] P_DATA_IN,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  Busy
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    // State names match the receive stage so both sides read the same way.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_par_en;
    logic                  r_par_bit;
    logic                  r_tx;
    logic                  r_busy;

    // Index of the data bit that goes out on the next DATA cycle.
    logic [CNT_W-1:0]      w_cnt_nxt;
    // Parity of the incoming byte: even = XOR, odd = XNOR.
    logic                  w_par_calc;

    assign w_cnt_nxt  = r_cnt + 1'b1;
    assign w_par_calc = PAR_TYP ? ~(^P_DATA_IN) : (^P_DATA_IN);

    assign TX_OUT = r_tx;
    assign Busy   = r_busy;

    // Frame sequencer; outputs are set on the edge that enters each state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_data    <= '0;
            r_par_en  <= 1'b0;
            r_par_bit <= 1'b0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_tx   <= 1'b1;
                    r_busy <= 1'b0;
                    r_cnt  <= '0;
                    if (DATA_VALID) begin
                        // Latch everything the frame needs so later input
                        // changes cannot disturb the frame in flight.
                        r_data    <= P_DATA_IN;
                        r_par_en  <= PAR_EN;
                        r_par_bit <= w_par_calc;
                        r_state   <= START;
                        r_tx      <= 1'b0;
                        r_busy    <= 1'b1;
                    end
                end
                START: begin
                    r_state <= DATA;
                    r_cnt   <= '0;
                    r_tx    <= r_data[0];
                    r_busy  <= 1'b1;
                end
                DATA: begin
                    r_busy <= 1'b1;
                    if (r_cnt == CNT_W'(DATA_WIDTH - 1)) begin
                        r_cnt <= '0;
                        if (r_par_en) begin
                            r_state <= PARITY;
                            r_tx    <= r_par_bit;
                        end else begin
                            r_state <= STOP;
                            r_tx    <= 1'b1;
                        end
                    end else begin
                        r_cnt <= w_cnt_nxt;
                        r_tx  <= r_data[w_cnt_nxt];
                    end
                end
                PARITY: begin
                    r_state <= STOP;
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b1;
                end
                STOP: begin
                    // A request seen here is dropped; acceptance resumes in IDLE.
                    r_state <= IDLE;
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: a frame-level model predicts {Busy, TX_OUT}
// every cycle, and directed frames are pinned against hand-written bit strings.
module tb_uart_tx_serializer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [W-1:0] P_DATA_IN = '0;
    logic         DATA_VALID = 1'b0;
    logic         PAR_EN = 1'b0;
    logic         PAR_TYP = 1'b0;
    logic         TX_OUT;
    logic         Busy;

    int checks = 0;
    int errors = 0;

    // Model state: expected {busy, tx} per cycle of the frame still to come.
    logic [1:0] exp_q[$];
    logic       cur_busy = 1'b0;
    logic       cur_tx = 1'b1;

    uart_tx_serializer #(.DATA_WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .P_DATA_IN  (P_DATA_IN),
        .DATA_VALID (DATA_VALID),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .TX_OUT     (TX_OUT),
        .Busy       (Busy)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: an idle line with an empty schedule accepts a
    // request and schedules the whole frame; one entry is consumed per edge.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            exp_q.delete();
            cur_busy = 1'b0;
            cur_tx   = 1'b1;
        end else begin
            if (exp_q.size() == 0 && !cur_busy && DATA_VALID) begin
                exp_q.push_back(2'b10);
                for (int i = 0; i < W; i++) exp_q.push_back({1'b1, P_DATA_IN[i]});
                if (PAR_EN) exp_q.push_back({1'b1, PAR_TYP ? ~(^P_DATA_IN) : (^P_DATA_IN)});
                exp_q.push_back(2'b11);
            end
            if (exp_q.size() > 0) {cur_busy, cur_tx} = exp_q.pop_front();
            else {cur_busy, cur_tx} = 2'b01;
        end
    end

    // Scoreboard compare on every falling edge.
    always @(negedge clk) begin
        check("cycle_busy_tx", {30'd0, Busy, TX_OUT}, {30'd0, cur_busy, cur_tx});
    end

    // Drive one frame and capture n cycles of TX_OUT starting at the start bit.
    // poke_at >= 0 raises a disturbing request (data FF, PAR_EN flipped)
    // right after that sample.
    task automatic run_frame(input string name, input logic [W-1:0] d, input logic pen,
                             input logic ptyp, input int n, input logic [15:0] exp_bits,
                             input int poke_at);
        logic [15:0] cap;
        int          bcnt;
        @(negedge clk);
        P_DATA_IN  = d;
        PAR_EN     = pen;
        PAR_TYP    = ptyp;
        DATA_VALID = 1'b1;
        @(negedge clk);
        DATA_VALID = 1'b0;
        cap  = '0;
        bcnt = 0;
        for (int i = 0; i < n; i++) begin
            cap  = {cap[14:0], TX_OUT};
            bcnt = bcnt + int'(Busy);
            if (i == poke_at) begin
                P_DATA_IN  = '1;
                PAR_EN     = ~PAR_EN;
                DATA_VALID = 1'b1;
            end else begin
                DATA_VALID = 1'b0;
            end
            if (i < n - 1) @(negedge clk);
        end
        @(negedge clk);
        DATA_VALID = 1'b0;
        check({name, "_bits"}, {16'd0, cap}, {16'd0, exp_bits});
        check({name, "_busy_cycles"}, bcnt, n);
        check({name, "_busy_after"}, {31'd0, Busy}, 32'd0);
        check({name, "_tx_after"}, {31'd0, TX_OUT}, 32'd1);
    endtask

    // Stimulus
    initial begin
        logic [31:0] cap2;
        int          bcnt2;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_tx", {31'd0, TX_OUT}, 32'd1);
        check("reset_busy", {31'd0, Busy}, 32'd0);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_tx", {31'd0, TX_OUT}, 32'd1);

        // No-parity A5: 0,1,0,1,0,0,1,0,1,1
        run_frame("a5_nopar", 8'hA5, 1'b0, 1'b0, 10, 16'b0101001011, -1);
        // Even parity 07 (parity 1): 0,1,1,1,0,0,0,0,0,1,1
        run_frame("07_even", 8'h07, 1'b1, 1'b0, 11, 16'b01110000011, -1);
        // Odd parity 03 (parity 1): 0,1,1,0,0,0,0,0,0,1,1
        run_frame("03_odd", 8'h03, 1'b1, 1'b1, 11, 16'b01100000011, -1);
        // All-zero frame with an FF request (and PAR_EN flip) during DATA
        run_frame("00_poke_data", 8'h00, 1'b0, 1'b0, 10, 16'b0000000001, 3);
        repeat (4) @(negedge clk);
        check("no_second_frame_busy", {31'd0, Busy}, 32'd0);
        // Request during STOP is dropped too
        run_frame("00_poke_stop", 8'h00, 1'b0, 1'b0, 10, 16'b0000000001, 9);
        repeat (4) @(negedge clk);
        check("stop_poke_busy", {31'd0, Busy}, 32'd0);

        // Back-to-back with DATA_VALID held: 55 then AA, one idle cycle between
        @(negedge clk);
        P_DATA_IN  = 8'h55;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        DATA_VALID = 1'b1;
        @(negedge clk);
        P_DATA_IN = 8'hAA;
        cap2  = '0;
        bcnt2 = 0;
        for (int i = 0; i < 21; i++) begin
            cap2  = {cap2[30:0], TX_OUT};
            bcnt2 = bcnt2 + int'(Busy);
            if (i == 10) check("b2b_gap_busy", {31'd0, Busy}, 32'd0);
            if (i < 20) @(negedge clk);
        end
        DATA_VALID = 1'b0;
        check("b2b_bits", cap2, {11'd0, 10'b0101010101, 1'b1, 10'b0010101011});
        check("b2b_busy_cycles", bcnt2, 20);
        repeat (3) @(negedge clk);
        check("b2b_idle_after", {31'd0, Busy}, 32'd0);

        // Asynchronous reset in the middle of DATA
        @(negedge clk);
        P_DATA_IN  = 8'h3C;
        DATA_VALID = 1'b1;
        @(negedge clk);
        DATA_VALID = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_reset_busy", {31'd0, Busy}, 32'd1);
        #2 reset = 1'b0;
        #1;
        check("async_reset_tx", {31'd0, TX_OUT}, 32'd1);
        check("async_reset_busy", {31'd0, Busy}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("post_reset_line", {30'd0, Busy, TX_OUT}, 32'd1);
        end

        // Reset released with DATA_VALID already high: first edge accepts
        reset = 1'b0;
        @(negedge clk);
        P_DATA_IN  = 8'h81;
        DATA_VALID = 1'b1;
        reset      = 1'b1;
        @(negedge clk);
        DATA_VALID = 1'b0;
        check("release_start_bit", {30'd0, Busy, TX_OUT}, 32'd2);
        repeat (14) @(negedge clk);
        check("release_frame_done", {31'd0, Busy}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
